pos_eqn_sweep_ctrl: RTL and testbench
=====================================

// Module: pos_eqn_sweep_ctrl
// PURPOSE
//   Sequencer that exhaustively drives the 3-input POS equation circuit (Y = A + B&C).
//   Steps every input combination, waits a settle window, samples Y and builds the truth table.
//   Compares the table against an expected mask and flags pass/fail.
//   Sits between a lab start button/host and the combinational equation circuit.
// PARAMETERS
//   N_IN    3       number of equation inputs; vector count V = 2**N_IN
//   SETTLE  2       wait cycles per vector before sampling Y; 0 allowed (sample cycle only)
//   EXPECT  8'hF8   expected truth table, width V; bit i = Y for input index i ({A,B,C}, A = MSB)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   start      in   1      one-cycle request to begin a sweep
//   abc        out  N_IN   drive to equation inputs {A,B,C}
//   y          in   1      equation output Y
//   busy       out  1      high while a sweep is in progress
//   done       out  1      one-cycle pulse when the sweep completes
//   truth      out  V      captured truth table; bit i = Y sampled for abc == i
//   pass       out  1      truth == EXPECT; valid from the done pulse until the next start
//   first_fail out  N_IN   [FAIL_CAPTURE_EN only] lowest mismatching index
//   fail_vld   out  1      [FAIL_CAPTURE_EN only] at least one mismatch recorded
// BEHAVIOUR
//   Reset values: abc=0, busy=0, done=0, truth=0, pass=0, first_fail=0, fail_vld=0; state IDLE.
//   Reset mid-sweep aborts immediately, returns all outputs to reset values, and produces no done pulse.
//   FSM states: IDLE -> WAIT -> SAMPLE -> (WAIT | FINISH) -> IDLE.
//     IDLE:   start=1 -> idx=0, abc=0, truth=0, pass=0, busy=1, wcnt=0; next state WAIT.
//     WAIT:   wcnt counts 0..SETTLE-1, then SAMPLE. If SETTLE=0, WAIT lasts 0 cycles (IDLE/SAMPLE go straight to SAMPLE).
//     SAMPLE: truth[idx] <= y.
//             If idx == V-1 -> FINISH.
//             Else idx <= idx+1, abc <= idx+1, wcnt <= 0 -> WAIT.
//     FINISH: busy <= 0, done <= 1 for exactly one cycle, pass <= (final truth == EXPECT) -> IDLE.
//   Timing:
//     abc changes only on the edge that enters WAIT/SAMPLE for a new vector, so Y settles >= SETTLE cycles.
//     Each vector takes SETTLE+1 cycles.
//     Latency from the start edge to the done pulse = V*(SETTLE+1)+1 cycles (default: 25).
//   Boundaries:
//     start while busy: ignored; no restart, no effect on truth.
//     start in the same cycle as FINISH: ignored (FSM is not yet in IDLE).
//     start on the cycle after done: accepted; clears truth and pass.
//     abc holds the last vector (V-1) in IDLE after a sweep; only start or rst returns it to 0.
//     idx is a N_IN+1-bit counter; termination is the compare at V-1, never wrap-around.
//     y is sampled only in SAMPLE; y is don't-care in every other cycle.
//     truth and pass hold their values until the next accepted start or rst.
// CONFIGURATION
//   FAIL_CAPTURE_EN defined:
//     first_fail and fail_vld ports exist.
//     In SAMPLE, if y != EXPECT[idx] and fail_vld=0: first_fail <= idx, fail_vld <= 1.
//     Both clear on an accepted start and on rst.
//   FAIL_CAPTURE_EN undefined:
//     ports and logic are absent; pass alone reports the result.
// TESTING
//   T1 reset: rst=1 for 2 cycles mid-idle -> all outputs 0, busy=0.
//   T2 good DUT: equation circuit connected, start pulse ->
//        abc steps 0..7, each value held 3 cycles; done pulses at cycle 25 after start;
//        truth=8'hF8, pass=1.
//   T3 faulty DUT: y forced to 0 for abc=3 ->
//        truth=8'hF0, pass=0; with FAIL_CAPTURE_EN: first_fail=3, fail_vld=1.
//   T4 start while busy: second start at cycle 10 ->
//        no restart; done still at cycle 25; truth=8'hF8.
//   T5 reset mid-sweep: rst at cycle 12 ->
//        busy=0, abc=0, truth=0, no done; a following start runs a full clean sweep, pass=1.
//   T6 SETTLE=0 build: start ->
//        one vector per cycle; done at cycle 9; truth=8'hF8.

Source files
------------

// File: rtl/pos_eqn_sweep_ctrl.sv
// Sweep sequencer for the 3-input POS equation circuit (Y = A + B&C).
// Drives every input combination, lets Y settle, samples it into a truth
// table and compares the table against EXPECT when the sweep ends.
// Optional feature macro: FAIL_CAPTURE_EN adds first_fail/fail_vld, which
// record the lowest mismatching input index.
module pos_eqn_sweep_ctrl #(
  parameter int unsigned           N_IN   = 3,
  parameter int unsigned           SETTLE = 2,
  parameter logic [(2**N_IN)-1:0]  EXPECT = 8'hF8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [N_IN-1:0]          abc,
  input  logic                     y,
  output logic                     busy,
  output logic                     done,
  output logic [(2**N_IN)-1:0]     truth,
  output logic                     pass
`ifdef FAIL_CAPTURE_EN
  ,
  output logic [N_IN-1:0]          first_fail,
  output logic                     fail_vld
`endif
);

  localparam int unsigned V          = 2**N_IN;
  localparam int unsigned IdxW       = N_IN + 1;
  localparam int unsigned WcntW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SettleLast = (SETTLE > 0) ? SETTLE - 1 : 0;

  typedef enum logic [1:0] {StIdle, StWait, StSample, StFinish} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;
  logic [N_IN-1:0]   abc_q, abc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [V-1:0]      truth_q, truth_d;
  logic              pass_q, pass_d;
`ifdef FAIL_CAPTURE_EN
  logic [N_IN-1:0]   first_fail_q, first_fail_d;
  logic              fail_vld_q, fail_vld_d;
`endif

  // Next-state and output logic; a settle window of zero skips WAIT entirely.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    truth_d = truth_q;
    pass_d  = pass_q;
`ifdef FAIL_CAPTURE_EN
    first_fail_d = first_fail_q;
    fail_vld_d   = fail_vld_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          abc_d   = '0;
          truth_d = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          wcnt_d  = '0;
`ifdef FAIL_CAPTURE_EN
          first_fail_d = '0;
          fail_vld_d   = 1'b0;
`endif
          state_d = (SETTLE == 0) ? StSample : StWait;
        end
      end
      StWait: begin
        if (wcnt_q == WcntW'(SettleLast)) begin
          state_d = StSample;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StSample: begin
        truth_d[idx_q[N_IN-1:0]] = y;
`ifdef FAIL_CAPTURE_EN
        if ((y != EXPECT[idx_q[N_IN-1:0]]) && !fail_vld_q) begin
          first_fail_d = idx_q[N_IN-1:0];
          fail_vld_d   = 1'b1;
        end
`endif
        // Terminate on the compare at the last vector, never on wrap-around.
        if (idx_q == IdxW'(V - 1)) begin
          state_d = StFinish;
        end else begin
          idx_d   = idx_q + 1'b1;
          abc_d   = idx_d[N_IN-1:0];
          wcnt_d  = '0;
          state_d = (SETTLE == 0) ? StSample : StWait;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (truth_q == EXPECT);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wcnt_q  <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      truth_q <= '0;
      pass_q  <= 1'b0;
`ifdef FAIL_CAPTURE_EN
      first_fail_q <= '0;
      fail_vld_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      truth_q <= truth_d;
      pass_q  <= pass_d;
`ifdef FAIL_CAPTURE_EN
      first_fail_q <= first_fail_d;
      fail_vld_q   <= fail_vld_d;
`endif
    end
  end

  assign abc   = abc_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign truth = truth_q;
  assign pass  = pass_q;
`ifdef FAIL_CAPTURE_EN
  assign first_fail = first_fail_q;
  assign fail_vld   = fail_vld_q;
`endif

endmodule

// File: tb/tb_pos_eqn_sweep_ctrl.sv
// Bench for pos_eqn_sweep_ctrl: one instance with SETTLE=2 and one with
// SETTLE=0, each driving its own equation circuit with an injectable fault mask.
module tb_pos_eqn_sweep_ctrl;

  localparam int        V   = 8;
  localparam logic [7:0] Exp = 8'hF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_req, sel;
  logic [7:0] fault;

  logic       start2, start0, y2, y0;
  logic [2:0] abc2, abc0;
  logic       busy2, busy0, done2, done0, pass2, pass0;
  logic [7:0] truth2, truth0;
`ifdef FAIL_CAPTURE_EN
  logic [2:0] ff2, ff0;
  logic       fv2, fv0;
`endif

  // Muxed view of whichever instance is under test (sel=1 -> SETTLE=0 build).
  logic [2:0] c_abc;
  logic       c_busy, c_done, c_pass;
  logic [7:0] c_truth;
`ifdef FAIL_CAPTURE_EN
  logic [2:0] c_ff;
  logic       c_fv;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Y = A + B&C from plain integer arithmetic on the input index.
  function automatic logic eqn(input int i);
    int a, b, c;
    a = i / 4;
    b = (i / 2) % 2;
    c = i % 2;
    return (a | (b & c)) != 0;
  endfunction

  always_comb begin
    start2 = start_req & ~sel;
    start0 = start_req & sel;
    y2     = eqn(int'(abc2)) ^ fault[abc2];
    y0     = eqn(int'(abc0)) ^ fault[abc0];
    c_abc   = sel ? abc0   : abc2;
    c_busy  = sel ? busy0  : busy2;
    c_done  = sel ? done0  : done2;
    c_pass  = sel ? pass0  : pass2;
    c_truth = sel ? truth0 : truth2;
`ifdef FAIL_CAPTURE_EN
    c_ff = sel ? ff0 : ff2;
    c_fv = sel ? fv0 : fv2;
`endif
  end

  pos_eqn_sweep_ctrl #(.N_IN(3), .SETTLE(2), .EXPECT(8'hF8)) dut (
    .clk(clk), .rst(rst), .start(start2), .abc(abc2), .y(y2), .busy(busy2),
    .done(done2), .truth(truth2), .pass(pass2)
`ifdef FAIL_CAPTURE_EN
    , .first_fail(ff2), .fail_vld(fv2)
`endif
  );

  pos_eqn_sweep_ctrl #(.N_IN(3), .SETTLE(0), .EXPECT(8'hF8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abc(abc0), .y(y0), .busy(busy0),
    .done(done0), .truth(truth0), .pass(pass0)
`ifdef FAIL_CAPTURE_EN
    , .first_fail(ff0), .fail_vld(fv0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected sweep result from the fault mask alone.
  task automatic model(input logic [7:0] fm, output logic [7:0] t, output bit p,
                       output int ff, output bit fv);
    t  = '0;
    ff = 0;
    fv = 1'b0;
    for (int i = 0; i < V; i++) t[i] = eqn(i) ^ fm[i];
    p = (t == Exp);
    for (int i = V - 1; i >= 0; i--) begin
      if (t[i] != Exp[i]) begin
        ff = i;
        fv = 1'b1;
      end
    end
  endtask

  // One full sweep. k counts cycles after the accepting start edge; extra is
  // the cycle during which a redundant start is held high (-1 for none).
  // With chain set, the task returns in the done cycle so the next call
  // issues its start there.
  task automatic sweep(input int s, input logic [7:0] fm, input int extra, input bit chain,
                       input logic [7:0] et, input bit ep, input int eff, input bit efv,
                       input string tag);
    int lat;
    lat       = V * (s + 1) + 1;
    sel       = (s == 0);
    fault     = fm;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    chk({tag, " truth cleared"}, c_truth, 0);
    chk({tag, " pass cleared"}, c_pass, 0);
`ifdef FAIL_CAPTURE_EN
    chk({tag, " fail_vld cleared"}, c_fv, 0);
`endif
    for (int k = 0; k <= lat; k++) begin
      int vec;
      vec = k / (s + 1);
      if (vec > V - 1) vec = V - 1;
      chk($sformatf("%s abc k=%0d", tag, k), c_abc, vec);
      chk($sformatf("%s busy k=%0d", tag, k), c_busy, (k < lat) ? 1 : 0);
      chk($sformatf("%s done k=%0d", tag, k), c_done, (k == lat) ? 1 : 0);
      if (k < lat) begin
        start_req = (k == extra);
        tick();
        start_req = 1'b0;
      end
    end
    chk({tag, " truth"}, c_truth, et);
    chk({tag, " pass"}, c_pass, ep);
`ifdef FAIL_CAPTURE_EN
    chk({tag, " fail_vld"}, c_fv, efv);
    if (efv) chk({tag, " first_fail"}, c_ff, eff);
`endif
    if (!chain) begin
      tick();
      chk({tag, " done single cycle"}, c_done, 0);
      chk({tag, " idle busy"}, c_busy, 0);
      chk({tag, " idle abc holds last"}, c_abc, V - 1);
      chk({tag, " truth held"}, c_truth, et);
      chk({tag, " pass held"}, c_pass, ep);
    end
  endtask

  typedef struct {
    int         s;
    logic [7:0] fm;
    int         extra;
    bit         chain;
    logic [7:0] et;
    bit         ep;
    int         eff;
    bit         efv;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] et;
    bit         ep, efv;
    int         eff, s, extra, seen_done;
    logic [7:0] fm;

    tbl[0] = '{2, 8'h00, -1, 1'b0, 8'hF8, 1'b1, 0, 1'b0}; // good circuit
    tbl[1] = '{2, 8'h08, -1, 1'b0, 8'hF0, 1'b0, 3, 1'b1}; // Y stuck 0 at abc=3
    tbl[2] = '{2, 8'h00, 10, 1'b0, 8'hF8, 1'b1, 0, 1'b0}; // start while busy
    tbl[3] = '{2, 8'h81, 24, 1'b0, 8'h79, 1'b0, 0, 1'b1}; // start during FINISH
    tbl[4] = '{2, 8'h06, -1, 1'b1, 8'hFE, 1'b0, 1, 1'b1}; // next start in done cycle
    tbl[5] = '{2, 8'h00, -1, 1'b0, 8'hF8, 1'b1, 0, 1'b0};
    tbl[6] = '{0, 8'h00, -1, 1'b0, 8'hF8, 1'b1, 0, 1'b0}; // SETTLE=0
    tbl[7] = '{0, 8'h10,  5, 1'b0, 8'hE8, 1'b0, 4, 1'b1};

    rst       = 1'b1;
    start_req = 1'b0;
    sel       = 1'b0;
    fault     = '0;
    tick();
    tick();
    chk("reset abc", abc2, 0);
    chk("reset busy", busy2, 0);
    chk("reset done", done2, 0);
    chk("reset truth", truth2, 0);
    chk("reset pass", pass2, 0);
    chk("reset0 abc", abc0, 0);
    chk("reset0 busy", busy0, 0);
`ifdef FAIL_CAPTURE_EN
    chk("reset first_fail", ff2, 0);
    chk("reset fail_vld", fv2, 0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      sweep(tbl[i].s, tbl[i].fm, tbl[i].extra, tbl[i].chain, tbl[i].et, tbl[i].ep,
            tbl[i].eff, tbl[i].efv, $sformatf("tbl%0d", i));
    end

    // Reset while idle after a sweep clears held truth/pass/abc.
    sweep(2, 8'h00, -1, 1'b0, 8'hF8, 1'b1, 0, 1'b0, "pre_rst");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("idle rst abc", abc2, 0);
    chk("idle rst truth", truth2, 0);
    chk("idle rst pass", pass2, 0);

    // Reset mid-sweep: abort with no done pulse, then a clean sweep.
    sel       = 1'b0;
    fault     = '0;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", busy2, 0);
    chk("midrst abc", abc2, 0);
    chk("midrst truth", truth2, 0);
    chk("midrst done", done2, 0);
    seen_done = 0;
    for (int k = 0; k < 30; k++) begin
      if (done2 || busy2) seen_done++;
      tick();
    end
    chk("midrst no done/busy after abort", seen_done, 0);
    sweep(2, 8'h00, -1, 1'b0, 8'hF8, 1'b1, 0, 1'b0, "post_rst");

    // Randomized sweeps checked against the model.
    for (int r = 0; r < 16; r++) begin
      s  = ($urandom_range(0, 1) == 1) ? 2 : 0;
      fm = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      extra = $urandom_range(0, V * (s + 1) + 1);
      if (extra == V * (s + 1) + 1) extra = -1;
      model(fm, et, ep, eff, efv);
      sweep(s, fm, extra, 1'b0, et, ep, eff, efv, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
